// File: rtl/me_pixel_serializer_if.sv
// Handshake bundle between the reference-memory word source, the pixel
// serializer and the downstream byte-shift chain.
interface me_pixel_serializer_if;
    logic         word_valid_i;
    logic         word_ready_o;
    logic [127:0] word_data_i;
    logic         pix_valid_o;
    logic         pix_ready_i;
    logic [7:0]   pix_data_o;
    logic         pix_last_o;
    logic [127:0] win_data_o;
    logic         win_valid_o;

    // The serializer itself.
    modport slave (
        input  word_valid_i,
        input  word_data_i,
        input  pix_ready_i,
        output word_ready_o,
        output pix_valid_o,
        output pix_data_o,
        output pix_last_o,
        output win_data_o,
        output win_valid_o
    );

    // Environment: supplies words and consumes pixels.
    modport master (
        output word_valid_i,
        output word_data_i,
        output pix_ready_i,
        input  word_ready_o,
        input  pix_valid_o,
        input  pix_data_o,
        input  pix_last_o,
        input  win_data_o,
        input  win_valid_o
    );
endinterface

// File: rtl/me_pixel_serializer.sv
// Serializes 128-bit reference words into one pixel per cycle (LSB first)
// and keeps a 16-pixel sliding window with row-boundary tracking.
module me_pixel_serializer #(
    parameter int unsigned ROW_WORDS = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   clear_i,
    me_pixel_serializer_if.slave   bus
);

    localparam int unsigned ROW_PIX = ROW_WORDS * 16;
    localparam int unsigned PW      = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(ROW_PIX - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [127:0]   hold_q,  hold_d;
    logic [3:0]     idx_q,   idx_d;
    logic [PW-1:0]  pcnt_q,  pcnt_d;
    logic [4:0]     fill_q,  fill_d;
    logic [127:0]   win_q,   win_d;
    logic           win_valid_q, win_valid_d;

    logic           full_s;
    logic [7:0]     pix_sel_s;
    logic           xfer_s;
    logic           last_byte_s;
    logic           word_ready_s;
    logic           accept_s;
    logic           pix_last_s;

    // Handshake decode; word_ready stays combinational so a new word can
    // land on the same edge as the last byte leaves.
    always_comb begin
        full_s       = (state_q == ST_SHIFT);
        pix_sel_s    = hold_q[{idx_q, 3'b000} +: 8];
        xfer_s       = full_s & bus.pix_ready_i & ~clear_i;
        last_byte_s  = (idx_q == 4'd15);
        word_ready_s = ~clear_i & (~full_s | (xfer_s & last_byte_s));
        accept_s     = bus.word_valid_i & word_ready_s;
        pix_last_s   = full_s & (pcnt_q == PCNT_LAST);
    end

    // Next-state computation for the serializer, window and row tracking.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        pcnt_d      = pcnt_q;
        fill_d      = fill_q;
        win_d       = win_q;
        if (clear_i) begin
            state_d = ST_EMPTY;
            hold_d  = 128'd0;
            idx_d   = 4'd0;
            pcnt_d  = '0;
            fill_d  = 5'd0;
            win_d   = 128'd0;
        end else begin
            if (xfer_s) begin
                idx_d = idx_q + 4'd1;
                win_d = {win_q[119:0], pix_sel_s};
                // Row end restarts the fill count; window contents are kept.
                if (pix_last_s) begin
                    pcnt_d = '0;
                    fill_d = 5'd0;
                end else begin
                    pcnt_d = pcnt_q + {{(PW-1){1'b0}}, 1'b1};
                    fill_d = (fill_q == 5'd16) ? 5'd16 : fill_q + 5'd1;
                end
                if (last_byte_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = state_q;
                end
            end else begin
                idx_d = idx_q;
            end
            if (accept_s) begin
                hold_d  = bus.word_data_i;
                idx_d   = 4'd0;
                state_d = ST_SHIFT;
            end else begin
                hold_d  = hold_q;
            end
        end
        win_valid_d = (fill_d == 5'd16);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_EMPTY;
            hold_q      <= 128'd0;
            idx_q       <= 4'd0;
            pcnt_q      <= '0;
            fill_q      <= 5'd0;
            win_q       <= 128'd0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            pcnt_q      <= pcnt_d;
            fill_q      <= fill_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign bus.word_ready_o = word_ready_s;
    assign bus.pix_valid_o  = full_s;
    assign bus.pix_data_o   = full_s ? pix_sel_s : 8'd0;
    assign bus.pix_last_o   = pix_last_s;
    assign bus.win_data_o   = win_q;
    assign bus.win_valid_o  = win_valid_q;

endmodule

// File: tb/tb_me_pixel_serializer.sv
// Randomized and directed bench for me_pixel_serializer against a queue-based
// pixel-stream reference model.
module tb_me_pixel_serializer;

    localparam int ROW_WORDS = 4;
    localparam int ROW_PIX   = ROW_WORDS * 16;

    logic clk;
    logic rst_n;
    logic clr;

    me_pixel_serializer_if bus ();

    me_pixel_serializer #(.ROW_WORDS(ROW_WORDS)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .clear_i (clr),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending pixels of the current word, row position,
    // window fill and window contents.
    logic [7:0]   pq[$];
    int           row_cnt;
    int           fill;
    logic [127:0] mwin;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pq.delete();
        row_cnt = 0;
        fill    = 0;
        mwin    = 128'd0;
    endtask

    function automatic logic [127:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: drive, check outputs mid-cycle, then advance the model.
    task automatic step(input logic wv, input logic [127:0] wd, input logic pr, input logic c);
        logic exp_valid, exp_ready, xf, acc;
        logic [7:0] px;
        @(negedge clk);
        bus.word_valid_i = wv;
        bus.word_data_i  = wd;
        bus.pix_ready_i  = pr;
        clr              = c;
        #1;
        exp_valid = (pq.size() != 0);
        exp_ready = !c && (pq.size() == 0 || (pq.size() == 1 && pr));
        chk("pix_valid", {127'd0, bus.pix_valid_o}, {127'd0, exp_valid});
        chk("word_ready", {127'd0, bus.word_ready_o}, {127'd0, exp_ready});
        if (exp_valid) begin
            chk("pix_data", {120'd0, bus.pix_data_o}, {120'd0, pq[0]});
        end
        chk("pix_last", {127'd0, bus.pix_last_o}, {127'd0, exp_valid && row_cnt == ROW_PIX - 1});
        chk("win_data", bus.win_data_o, mwin);
        chk("win_valid", {127'd0, bus.win_valid_o}, {127'd0, fill == 16});
        xf  = exp_valid && pr && !c;
        acc = wv && exp_ready;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            if (xf) begin
                px   = pq.pop_front();
                mwin = {mwin[119:0], px};
                if (row_cnt == ROW_PIX - 1) begin
                    row_cnt = 0;
                    fill    = 0;
                end else begin
                    row_cnt++;
                    if (fill < 16) fill++;
                end
            end
            if (acc) begin
                for (int k = 0; k < 16; k++) pq.push_back(wd[8*k +: 8]);
            end
        end
    endtask

    logic [127:0] w;
    logic [127:0] exp_w;

    initial begin
        rst_n            = 1'b0;
        clr              = 1'b0;
        bus.word_valid_i = 1'b0;
        bus.word_data_i  = 128'd0;
        bus.pix_ready_i  = 1'b0;
        model_reset();
        #12;
        chk("rst_word_ready", {127'd0, bus.word_ready_o}, 128'd1);
        chk("rst_pix_valid", {127'd0, bus.pix_valid_o}, 128'd0);
        chk("rst_pix_data", {120'd0, bus.pix_data_o}, 128'd0);
        chk("rst_win_data", bus.win_data_o, 128'd0);
        chk("rst_win_valid", {127'd0, bus.win_valid_o}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Byte order with an ascending word.
        for (int k = 0; k < 16; k++) begin
            w[8*k +: 8]     = 8'(k);
            exp_w[8*k +: 8] = 8'(15 - k);
        end
        step(1'b1, w, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 128'd0, 1'b1, 1'b0);
        #1;
        chk("order_win", bus.win_data_o, exp_w);
        chk("order_win_valid", {127'd0, bus.win_valid_o}, 128'd1);

        // Back-to-back words across a row boundary (row-end collision included).
        step(1'b0, 128'd0, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) step(1'b1, rand_word(), 1'b1, 1'b0);

        // Stall at byte 7.
        step(1'b0, 128'd0, 1'b0, 1'b1);
        w = rand_word();
        step(1'b1, w, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 128'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, rand_word(), 1'b0, 1'b0);
        #1;
        chk("stall_hold", {120'd0, bus.pix_data_o}, {120'd0, w[63:56]});
        for (int i = 0; i < 12; i++) step(1'b0, 128'd0, 1'b1, 1'b0);

        // Clear at byte 9 with a concurrent word offered.
        step(1'b0, 128'd0, 1'b0, 1'b1);
        step(1'b1, rand_word(), 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 128'd0, 1'b1, 1'b0);
        step(1'b1, rand_word(), 1'b1, 1'b1);
        #1;
        chk("clr_pix_valid", {127'd0, bus.pix_valid_o}, 128'd0);
        chk("clr_win", bus.win_data_o, 128'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 128'd0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), rand_word(),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) < 2));
        end

        // Asynchronous reset in the middle of a word.
        step(1'b0, 128'd0, 1'b0, 1'b1);
        step(1'b1, rand_word(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 128'd0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pix_valid", {127'd0, bus.pix_valid_o}, 128'd0);
        chk("mid_rst_pix_data", {120'd0, bus.pix_data_o}, 128'd0);
        chk("mid_rst_pix_last", {127'd0, bus.pix_last_o}, 128'd0);
        chk("mid_rst_win", bus.win_data_o, 128'd0);
        chk("mid_rst_win_valid", {127'd0, bus.win_valid_o}, 128'd0);
        chk("mid_rst_word_ready", {127'd0, bus.word_ready_o}, 128'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 128'd0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, rand_word(), 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
